// File: rtl/rr_sel_arbiter.sv
// Four-channel round-robin arbiter driving the select code of a 4:1 data selector.
// A grant is held until done, requester withdrawal, or dwell timeout, then always drops for at least one idle cycle.
module rr_sel_arbiter #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TW      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] sel,
   output logic [3:0] grant,
   output logic       valid,
   output logic       timeout_flag,
   output logic       state_dbg
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam bit            TMO_EN   = (TIMEOUT != 0);
   localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT - 1) : '0;

   logic [0:0]    state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    grant_q, grant_d;
   logic          valid_q, valid_d;
   logic          tflag_q, tflag_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [TW-1:0] timer_q, timer_d;

   logic [1:0] pick;
   logic       end_done, end_wd, end_tmo;

   // Walk the search order backwards so the channel closest to ptr wins.
   always_comb begin
      logic [1:0] idx;
      idx  = '0;
      pick = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (req[idx]) pick = idx;
      end
   end

   assign end_done = done;
   assign end_wd   = ~req[sel_q];
   assign end_tmo  = TMO_EN && (timer_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      valid_d = valid_q;
      tflag_d = 1'b0;
      ptr_d   = ptr_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               sel_d   = pick;
               grant_d = 4'b0001 << pick;
               valid_d = 1'b1;
               timer_d = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
            if (end_done || end_wd || end_tmo) begin
               valid_d = 1'b0;
               grant_d = '0;
               ptr_d   = sel_q + 2'd1;
               state_d = S_IDLE;
               tflag_d = end_tmo && !end_done && !end_wd;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         tflag_q <= 1'b0;
         ptr_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         tflag_q <= tflag_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
      end
   end

   assign sel          = sel_q;
   assign grant        = grant_q;
   assign valid        = valid_q;
   assign timeout_flag = tflag_q;
   assign state_dbg    = state_q[0];

endmodule
